apb_spi_fifo_if: RTL and testbench
==================================

APB_SPI_FIFO_IF -- requirements
Module: apb_spi_fifo_if

Interface
REQ-001 Parameter DATA_W, default 8, SPI data-register and pwdata/prdata width; legal 8..32.
REQ-002 Parameter FIFO_DEPTH, default 4, entries in each of the TX and RX FIFOs; power of two, 2..16.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports are pclk and preset_n.
REQ-004 Ports (name, direction, width, meaning):
- pclk  in  1  clock.
- preset_n  in  1  async active-low reset.
- psel, penable, pwrite  in  1  APB controls.
- paddr  in  3  register address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data.
- pready, pslverr  out  1  APB response.
- ss, tip, receive_data  in  1  slave select, transfer-in-progress, RX byte valid pulse.
- miso_data  in  DATA_W  received word.
- send_data  out  1  one-cycle transfer launch.
- mosi_data  out  DATA_W  word to shift.
- mstr, cpol, cpha, lsbfe, spiswai  out  1  CR1/CR2 decodes.
- sppr, spr  out  3  baud prescale/select.
- spi_mode  out  2  run=00, wait=01, stop=10.
- spi_interrupt_request  out  1  level interrupt.

Function
REQ-005 APB access phase = psel&penable; pready SHALL be 1 in every access phase (no wait states), else 0.
REQ-006 Map: 0 CR1, 1 CR2 (write mask 0x1B), 2 BR (write mask 0x77), 3 SR read-only, 5 DR; CR1/CR2/BR are 8-bit, using pwdata[7:0]; reads zero-extend.
REQ-007 CR1 bits: [7]spie [6]spe [5]sptie [4]mstr [3]cpol [2]cpha [1]ssoe [0]lsbfe; CR2 [4]modfen [1]spiswai; BR [6:4]sppr [2:0]spr.
REQ-008 DR write SHALL push pwdata to TX FIFO; DR read SHALL return RX FIFO head combinationally and pop it at the access phase.
REQ-009 SR: [7]spif=RX non-empty, [5]sptef=TX not full, [4]modf, [3]txfull, [1]rxovr, others 0.
REQ-010 modf = !ss & mstr & modfen & !ssoe, combinational.
REQ-011 receive_data with spi_mode!=stop SHALL push miso_data to RX FIFO; if RX full the word is dropped and rxovr set; rxovr is sticky, cleared by an SR read access.
REQ-012 Same-cycle push and pop on one FIFO SHALL both take effect, including at full (count unchanged) and empty (pop ignored, push kept); pointers wrap modulo FIFO_DEPTH.
REQ-013 spi_mode FSM: run: !spe->wait; wait: spe->run, else spiswai->stop; stop: spe->run, else !spiswai->wait.
REQ-014 Launch FSM IDLE/LAUNCH/BUSY: IDLE->LAUNCH when TX non-empty, spe=1, spi_mode!=stop, tip=0; LAUNCH lasts one cycle with send_data=1, mosi_data=popped TX head (held until next launch); LAUNCH->BUSY; BUSY->IDLE after tip seen 1 then 0.
REQ-015 spi_interrupt_request = (spie & (spif|modf|rxovr)) | (sptie & sptef).
REQ-016 A TX push arriving while the FIFO is empty SHALL not launch in the same cycle (minimum one-cycle push-to-launch latency).

Reset
REQ-017 On preset_n=0 asynchronously: CR1=0x04, CR2=0x00, BR=0x00, FIFOs empty, rxovr=0, spi_mode=run, launch FSM=IDLE, send_data=0, mosi_data=0, prdata=0.
REQ-018 Reset during BUSY or mid-APB access SHALL abandon the operation; no launch occurs on the first cycle after release.

Configuration
REQ-019 Macro APB_SPI_PSLVERR_EN defined: pslverr=1 in access phase for unmapped address, SR write, DR write with TX full, DR read with RX empty; FIFOs and registers unchanged by such accesses.
REQ-020 Macro undefined: pslverr tied 0; the same accesses are silently ignored, erroneous reads return 0.

Verification
REQ-021 Reset, read addresses 0,1,2,3 -> 0x04, 0x00, 0x00, 0x20.
REQ-022 Write CR2=0xFF, BR=0xFF -> reads 0x1B, 0x77; spiswai=1, sppr=7, spr=7.
REQ-023 CR1=0x50, write DR 0xA5,0x3C -> send_data pulse with mosi_data=0xA5; tip 1 for 8 cycles then 0; second pulse 0x3C.
REQ-024 FIFO_DEPTH+1 receive_data pulses with 0x11.. -> spif=1, rxovr=1, IRQ=1 when spie=1; DR reads return first FIFO_DEPTH words in order; SR read clears rxovr.
REQ-025 With APB_SPI_PSLVERR_EN: DR read on empty RX and write to paddr 6 -> pslverr=1, pready=1; without macro -> pslverr=0, prdata=0.
REQ-026 CR1 spe=0 then CR2 spiswai=1 -> spi_mode run->wait->stop; set spe=1 -> run next cycle.

Source files
------------

// File: rtl/apb_spi_fifo_if.sv
// APB register front-end for an SPI master/slave core with TX/RX word FIFOs,
// run/wait/stop mode tracking and transfer launch. Define APB_SPI_PSLVERR_EN for APB error responses.

module apb_spi_fifo_if_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; empty/full come from the reset count, so stale words are never observed.
  always_ff @(posedge pclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module apb_spi_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [2:0]        paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ss,
  input  logic              tip,
  input  logic              receive_data,
  input  logic [DATA_W-1:0] miso_data,
  output logic              send_data,
  output logic [DATA_W-1:0] mosi_data,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              spi_interrupt_request
);
  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_LAUNCH,
    L_BUSY
  } launch_e;

  logic [7:0] cr1_q, cr2_q, br_q;
  logic       rxovr_q;
  mode_e      mode_q, mode_d;
  launch_e    state_q, state_d;
  logic       tip_seen_q, tip_seen_d;
  logic [DATA_W-1:0] mosi_q;

  logic access, wr_access, rd_access;
  logic spie, spe, sptie, ssoe, modfen, modf;
  logic tx_push_req, tx_pop, tx_empty, tx_full;
  logic rx_push_req, rx_pop_req, rx_empty, rx_full, rx_drop;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [7:0] sr;

  assign access    = psel & penable;
  assign wr_access = access & pwrite;
  assign rd_access = access & ~pwrite;
  assign pready    = access;

  assign spie    = cr1_q[7];
  assign spe     = cr1_q[6];
  assign sptie   = cr1_q[5];
  assign mstr    = cr1_q[4];
  assign cpol    = cr1_q[3];
  assign cpha    = cr1_q[2];
  assign ssoe    = cr1_q[1];
  assign lsbfe   = cr1_q[0];
  assign modfen  = cr2_q[4];
  assign spiswai = cr2_q[1];
  assign sppr    = br_q[6:4];
  assign spr     = br_q[2:0];

  assign modf = ~ss & mstr & modfen & ~ssoe;
  assign sr   = {~rx_empty, 1'b0, ~tx_full, modf, tx_full, 1'b0, rxovr_q, 1'b0};

  assign spi_interrupt_request = (spie & (~rx_empty | modf | rxovr_q)) | (sptie & ~tx_full);

  assign tx_push_req = wr_access & (paddr == ADDR_DR);
  assign rx_pop_req  = rd_access & (paddr == ADDR_DR);
  assign rx_push_req = receive_data & (mode_q != MODE_STOP);
  // A full RX FIFO only drops the word when no DR read frees a slot this cycle.
  assign rx_drop     = rx_push_req & rx_full & ~rx_pop_req;

  apb_spi_fifo_if_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .pclk     (pclk),
    .preset_n (preset_n),
    .push     (tx_push_req),
    .wdata    (pwdata),
    .pop      (tx_pop),
    .rdata    (tx_head),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  apb_spi_fifo_if_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .pclk     (pclk),
    .preset_n (preset_n),
    .push     (rx_push_req),
    .wdata    (miso_data),
    .pop      (rx_pop_req),
    .rdata    (rx_head),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cr1_q   <= 8'h04;
      cr2_q   <= 8'h00;
      br_q    <= 8'h00;
      rxovr_q <= 1'b0;
    end else begin
      if (wr_access) begin
        case (paddr)
          ADDR_CR1: cr1_q <= pwdata[7:0];
          ADDR_CR2: cr2_q <= pwdata[7:0] & 8'h1B;
          ADDR_BR:  br_q  <= pwdata[7:0] & 8'h77;
          default:  ;
        endcase
      end
      // An overflow in the same cycle as an SR read stays visible for the next read.
      if (rx_drop)
        rxovr_q <= 1'b1;
      else if (rd_access && paddr == ADDR_SR)
        rxovr_q <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    prdata = '0;
    if (rd_access) begin
      case (paddr)
        ADDR_CR1: prdata[7:0] = cr1_q;
        ADDR_CR2: prdata[7:0] = cr2_q;
        ADDR_BR:  prdata[7:0] = br_q;
        ADDR_SR:  prdata[7:0] = sr;
        ADDR_DR:  if (!rx_empty) prdata = rx_head;
        default:  prdata = '0;
      endcase
    end
  end

`ifdef APB_SPI_PSLVERR_EN
  logic access_err;

  always_comb begin
    access_err = 1'b0;
    case (paddr)
      ADDR_CR1, ADDR_CR2, ADDR_BR: access_err = 1'b0;
      ADDR_SR: access_err = pwrite;
      ADDR_DR: access_err = pwrite ? (tx_full & ~tx_pop) : rx_empty;
      default: access_err = 1'b1;
    endcase
  end

  assign pslverr = access & access_err;
`else
  assign pslverr = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:  if (!spe) mode_d = MODE_WAIT;
      MODE_WAIT: if (spe) mode_d = MODE_RUN;
                 else if (spiswai) mode_d = MODE_STOP;
      MODE_STOP: if (spe) mode_d = MODE_RUN;
                 else if (!spiswai) mode_d = MODE_WAIT;
      default:   mode_d = MODE_RUN;
    endcase
  end

  // The TX head is popped on the IDLE->LAUNCH edge, so a word pushed into an
  // empty FIFO is first visible to this decision one cycle later.
  always_comb begin
    state_d    = state_q;
    tip_seen_d = tip_seen_q;
    tx_pop     = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (!tx_empty && spe && mode_q != MODE_STOP && !tip) begin
          state_d = L_LAUNCH;
          tx_pop  = 1'b1;
        end
      end
      L_LAUNCH: begin
        state_d    = L_BUSY;
        tip_seen_d = tip;
      end
      L_BUSY: begin
        if (tip) begin
          tip_seen_d = 1'b1;
        end else if (tip_seen_q) begin
          state_d    = L_IDLE;
          tip_seen_d = 1'b0;
        end
      end
      default: begin
        state_d    = L_IDLE;
        tip_seen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      mode_q     <= MODE_RUN;
      state_q    <= L_IDLE;
      tip_seen_q <= 1'b0;
      mosi_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      tip_seen_q <= tip_seen_d;
      if (tx_pop) mosi_q <= tx_head;
    end
  end

  assign send_data = (state_q == L_LAUNCH);
  assign mosi_data = mosi_q;
  assign spi_mode  = mode_q;
endmodule

// File: tb/tb_apb_spi_fifo_if.sv
// Self-checking bench for apb_spi_fifo_if: scoreboard queues for TX launches
// and RX reads, register/mode/error checks. Honours APB_SPI_PSLVERR_EN.

module tb_apb_spi_fifo_if;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef APB_SPI_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              preset_n;
  logic              psel, penable, pwrite;
  logic [2:0]        paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;
  logic              ss, tip, receive_data;
  logic [DATA_W-1:0] miso_data, mosi_data;
  logic              send_data;
  logic              mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0]        sppr, spr;
  logic [1:0]        spi_mode;
  logic              spi_interrupt_request;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_tx [$];
  logic [DATA_W-1:0] exp_rx [$];

  always #5 pclk = ~pclk;

  apb_spi_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pclk                  (pclk),
    .preset_n              (preset_n),
    .psel                  (psel),
    .penable               (penable),
    .pwrite                (pwrite),
    .paddr                 (paddr),
    .pwdata                (pwdata),
    .prdata                (prdata),
    .pready                (pready),
    .pslverr               (pslverr),
    .ss                    (ss),
    .tip                   (tip),
    .receive_data          (receive_data),
    .miso_data             (miso_data),
    .send_data             (send_data),
    .mosi_data             (mosi_data),
    .mstr                  (mstr),
    .cpol                  (cpol),
    .cpha                  (cpha),
    .lsbfe                 (lsbfe),
    .spiswai               (spiswai),
    .sppr                  (sppr),
    .spr                   (spr),
    .spi_mode              (spi_mode),
    .spi_interrupt_request (spi_interrupt_request)
  );

  task automatic idle_inputs();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tip = 1'b0; receive_data = 1'b0; miso_data = '0; ss = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    preset_n = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic apb_write(input logic [2:0] addr, input logic [7:0] data,
                           output logic rdy, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = DATA_W'(data);
    @(negedge pclk);
    penable = 1'b1;
    #1;
    rdy = pready;
    err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] addr, input logic do_rx,
                          input logic [DATA_W-1:0] rx_word,
                          output logic [DATA_W-1:0] data, output logic rdy, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge pclk);
    penable = 1'b1;
    if (do_rx) begin
      receive_data = 1'b1;
      miso_data    = rx_word;
    end
    #1;
    data = prdata;
    rdy  = pready;
    err  = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; receive_data = 1'b0;
  endtask

  task automatic rx_pulse(input logic [DATA_W-1:0] word);
    @(negedge pclk);
    receive_data = 1'b1;
    miso_data    = word;
    @(negedge pclk);
    receive_data = 1'b0;
  endtask

  // Scoreboard consumer: waits for each launch, checks the word, then plays an 8-cycle transfer on tip.
  task automatic tx_monitor(input int n_pulses);
    logic [DATA_W-1:0] exp;
    int   waited;
    logic bad;
    for (int p = 0; p < n_pulses; p++) begin
      waited = 0;
      while (send_data !== 1'b1 && waited < 200) begin
        @(negedge pclk);
        waited++;
      end
      n_checks++;
      if (send_data !== 1'b1) begin
        n_errors++;
        $display("FAIL launch_timeout: send_data=%b after %0d cycles, required 1", send_data, waited);
        return;
      end
      if (exp_tx.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_launch: mosi_data=%h, no word expected", mosi_data);
        return;
      end
      exp = exp_tx.pop_front();
      if (mosi_data !== exp) begin
        n_errors++;
        $display("FAIL launch_word: mosi_data=%h required %h", mosi_data, exp);
      end
      @(negedge pclk);
      n_checks++;
      if (send_data !== 1'b0) begin
        n_errors++;
        $display("FAIL launch_width: send_data=%b one cycle later, required 0", send_data);
      end
      tip = 1'b1;
      bad = 1'b0;
      repeat (8) begin
        @(negedge pclk);
        if (send_data !== 1'b0 || mosi_data !== exp) bad = 1'b1;
      end
      tip = 1'b0;
      n_checks++;
      if (bad) begin
        n_errors++;
        $display("FAIL busy_hold: send_data=%b mosi_data=%h during tip, required 0 and %h", send_data, mosi_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic r, e;
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h04, 8'h00, 8'h00, 8'h20};
    @(negedge pclk);
    #2;
    idle_inputs();
    preset_n = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    #1;
    n_checks++;
    if (send_data !== 1'b0 || mosi_data !== '0 || spi_mode !== 2'b00 || prdata !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: send=%b mosi=%h mode=%b prdata=%h, required 0 00 00 00",
               send_data, mosi_data, spi_mode, prdata);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (send_data !== 1'b0) begin
      n_errors++;
      $display("FAIL no_launch_after_reset: send_data=%b required 0", send_data);
    end
    for (int a = 0; a < 4; a++) begin
      apb_read(3'(a), 1'b0, '0, d, r, e);
      n_checks++;
      if (d !== DATA_W'(exp_tab[a]) || r !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_read_%0d: prdata=%h pready=%b, required %h 1", a, d, r, exp_tab[a]);
      end
    end
  endtask

  task automatic test_cr_masks();
    logic [DATA_W-1:0] d;
    logic r, e;
    do_reset();
    apb_write(3'd1, 8'hFF, r, e);
    apb_write(3'd2, 8'hFF, r, e);
    apb_write(3'd0, 8'h1D, r, e);
    apb_read(3'd1, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h1B) begin n_errors++; $display("FAIL cr2_mask: prdata=%h required 1b", d); end
    apb_read(3'd2, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h77) begin n_errors++; $display("FAIL br_mask: prdata=%h required 77", d); end
    apb_read(3'd0, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h1D) begin n_errors++; $display("FAIL cr1_read: prdata=%h required 1d", d); end
    n_checks++;
    if ({spiswai, sppr, spr, mstr, cpol, cpha, lsbfe} !== {1'b1, 3'd7, 3'd7, 4'b1111}) begin
      n_errors++;
      $display("FAIL decodes: spiswai=%b sppr=%0d spr=%0d mstr/cpol/cpha/lsbfe=%b%b%b%b, required 1 7 7 1111",
               spiswai, sppr, spr, mstr, cpol, cpha, lsbfe);
    end
    ss = 1'b0;
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h30 || spi_interrupt_request !== 1'b0) begin
      n_errors++;
      $display("FAIL modf: sr=%h irq=%b, required 30 0", d, spi_interrupt_request);
    end
    ss = 1'b1;
    apb_write(3'd0, 8'h20, r, e);
    n_checks++;
    if (spi_interrupt_request !== 1'b1) begin
      n_errors++;
      $display("FAIL sptie_irq: irq=%b required 1", spi_interrupt_request);
    end
  endtask

  task automatic test_launch();
    logic r, e;
    do_reset();
    apb_write(3'd0, 8'h50, r, e);
    fork
      begin
        exp_tx.push_back(8'hA5);
        apb_write(3'd5, 8'hA5, r, e);
        exp_tx.push_back(8'h3C);
        apb_write(3'd5, 8'h3C, r, e);
      end
      tx_monitor(2);
    join
    n_checks++;
    if (exp_tx.size() != 0) begin
      n_errors++;
      $display("FAIL launch_count: %0d words not launched, required 0", exp_tx.size());
    end
  endtask

  task automatic test_tx_full();
    logic [DATA_W-1:0] d;
    logic r, e;
    logic bad;
    do_reset();
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      if (i < FIFO_DEPTH) exp_tx.push_back(DATA_W'(8'hC0 + i));
      apb_write(3'd5, 8'(8'hC0 + i), r, e);
      n_checks++;
      if (e !== ((i == FIFO_DEPTH) ? EXP_ERR : 1'b0) || r !== 1'b1) begin
        n_errors++;
        $display("FAIL tx_write_%0d: pslverr=%b pready=%b, required %b 1", i, e, r,
                 (i == FIFO_DEPTH) ? EXP_ERR : 1'b0);
      end
    end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h08) begin n_errors++; $display("FAIL tx_full_sr: sr=%h required 08", d); end
    apb_write(3'd0, 8'h40, r, e);
    tx_monitor(FIFO_DEPTH);
    bad = 1'b0;
    repeat (20) begin
      @(negedge pclk);
      if (send_data !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || exp_tx.size() != 0) begin
      n_errors++;
      $display("FAIL tx_drain: extra_launch=%b left=%0d, required 0 0", bad, exp_tx.size());
    end
  endtask

  task automatic test_rx_overflow();
    logic [DATA_W-1:0] d, exp;
    logic r, e;
    do_reset();
    apb_write(3'd0, 8'h80, r, e);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      exp_rx.push_back(DATA_W'(8'h11 + i));
      rx_pulse(DATA_W'(8'h11 + i));
    end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'hA0 || spi_interrupt_request !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_full_sr: sr=%h irq=%b, required a0 1", d, spi_interrupt_request);
    end
    exp_rx.push_back(8'h55);
    apb_read(3'd5, 1'b1, 8'h55, d, r, e);
    exp = exp_rx.pop_front();
    n_checks++;
    if (d !== exp) begin n_errors++; $display("FAIL rx_push_pop_full: prdata=%h required %h", d, exp); end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'hA0) begin n_errors++; $display("FAIL rx_no_overflow: sr=%h required a0", d); end
    rx_pulse(8'h66);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      apb_read(3'd5, 1'b0, '0, d, r, e);
      exp = exp_rx.pop_front();
      n_checks++;
      if (d !== exp) begin n_errors++; $display("FAIL rx_read_%0d: prdata=%h required %h", i, d, exp); end
    end
    n_checks++;
    if (spi_interrupt_request !== 1'b1) begin
      n_errors++;
      $display("FAIL rxovr_irq: irq=%b required 1", spi_interrupt_request);
    end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h22) begin n_errors++; $display("FAIL rxovr_set: sr=%h required 22", d); end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h20 || spi_interrupt_request !== 1'b0) begin
      n_errors++;
      $display("FAIL rxovr_clear: sr=%h irq=%b, required 20 0", d, spi_interrupt_request);
    end
    apb_read(3'd5, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== '0 || e !== EXP_ERR || r !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_empty_read: prdata=%h pslverr=%b pready=%b, required 00 %b 1", d, e, r, EXP_ERR);
    end
  endtask

  task automatic test_errors();
    logic [DATA_W-1:0] d;
    logic r, e;
    do_reset();
    apb_write(3'd6, 8'hFF, r, e);
    n_checks++;
    if (e !== EXP_ERR || r !== 1'b1) begin
      n_errors++;
      $display("FAIL unmapped_write: pslverr=%b pready=%b, required %b 1", e, r, EXP_ERR);
    end
    apb_read(3'd6, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== '0 || e !== EXP_ERR) begin
      n_errors++;
      $display("FAIL unmapped_read: prdata=%h pslverr=%b, required 00 %b", d, e, EXP_ERR);
    end
    apb_write(3'd3, 8'hFF, r, e);
    n_checks++;
    if (e !== EXP_ERR) begin n_errors++; $display("FAIL sr_write: pslverr=%b required %b", e, EXP_ERR); end
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h20 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL sr_unchanged: sr=%h pslverr=%b, required 20 0", d, e);
    end
  endtask

  task automatic test_spi_mode();
    logic [DATA_W-1:0] d;
    logic r, e;
    do_reset();
    apb_write(3'd0, 8'h00, r, e);
    n_checks++;
    if (spi_mode !== 2'b01) begin n_errors++; $display("FAIL mode_wait: spi_mode=%b required 01", spi_mode); end
    apb_write(3'd1, 8'h02, r, e);
    @(negedge pclk);
    n_checks++;
    if (spi_mode !== 2'b10) begin n_errors++; $display("FAIL mode_stop: spi_mode=%b required 10", spi_mode); end
    rx_pulse(8'h77);
    apb_read(3'd3, 1'b0, '0, d, r, e);
    n_checks++;
    if (d !== 8'h20) begin n_errors++; $display("FAIL stop_rx_ignored: sr=%h required 20", d); end
    apb_write(3'd0, 8'h40, r, e);
    n_checks++;
    if (spi_mode !== 2'b10) begin n_errors++; $display("FAIL mode_hold: spi_mode=%b required 10", spi_mode); end
    @(negedge pclk);
    n_checks++;
    if (spi_mode !== 2'b00) begin n_errors++; $display("FAIL mode_run: spi_mode=%b required 00", spi_mode); end
  endtask

  initial begin
    idle_inputs();
    preset_n = 1'b1;
    test_reset();
    test_cr_masks();
    test_launch();
    test_reset();
    test_tx_full();
    test_rx_overflow();
    test_errors();
    test_spi_mode();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
